// File: rtl/sl_transmitter.sv
// Serial-line word transmitter: serializes an 8..32-bit word LSB first onto the
// two-wire SL bus (sl0 = zeroes line, sl1 = ones line), with optional even parity.
module sl_transmitter #(
    parameter int unsigned HALF_BIT   = 8,
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic        cfg_enable,
    input  logic [5:0]  cfg_bit_cnt,
    input  logic        cfg_parity_en,
    output logic        sl0,
    output logic        sl1,
    output logic        busy,
    output logic        done,
    output logic        cfg_err
);

    localparam int unsigned PH_MAX = (HALF_BIT > GAP_CYCLES) ? HALF_BIT : GAP_CYCLES;
    localparam int unsigned PW     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam logic [PW-1:0] HB_LAST  = PW'(HALF_BIT - 1);
    localparam logic [PW-1:0] GAP_LAST = PW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ACTIVE,
        GAP,
        STOP_ACTIVE,
        STOP_GAP,
        IFG
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [5:0]    bit_q, bit_d;
    logic [5:0]    total_q, total_d;
    logic [32:0]   shift_q, shift_d;
    logic          sl0_q, sl0_d;
    logic          sl1_q, sl1_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          cfg_err_q, cfg_err_d;

    logic          accept;
    logic          legal;
    logic [32:0]   mask;
    logic [32:0]   data_m;
    logic          parity;

    assign tx_ready = (state_q == IDLE) & cfg_enable;
    assign accept   = tx_valid & tx_ready;
    assign legal    = (cfg_bit_cnt >= 6'd8) && (cfg_bit_cnt <= 6'd32);

    // Parity bit is parked just above the data so plain right-shifting sends it last.
    always_comb begin
        mask   = (cfg_bit_cnt >= 6'd32) ? 33'h0_FFFF_FFFF : ((33'd1 << cfg_bit_cnt) - 33'd1);
        data_m = {1'b0, tx_data} & mask;
        parity = ^data_m;
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        total_d   = total_q;
        shift_d   = shift_q;
        cfg_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (legal) begin
                        state_d = ACTIVE;
                        phase_d = '0;
                        bit_d   = '0;
                        total_d = cfg_bit_cnt + {5'd0, cfg_parity_en};
                        shift_d = data_m | ((cfg_parity_en && parity) ? (33'd1 << cfg_bit_cnt) : '0);
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                if (phase_q == HB_LAST) begin
                    phase_d = '0;
                    state_d = GAP;
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            GAP: begin
                if (phase_q == HB_LAST) begin
                    phase_d = '0;
                    if (bit_q == total_q - 6'd1) begin
                        state_d = STOP_ACTIVE;
                    end else begin
                        state_d = ACTIVE;
                        bit_d   = bit_q + 6'd1;
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            STOP_ACTIVE: begin
                if (phase_q == HB_LAST) begin
                    phase_d = '0;
                    state_d = STOP_GAP;
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            STOP_GAP: begin
                if (phase_q == HB_LAST) begin
                    phase_d = '0;
                    state_d = IFG;
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            IFG: begin
                if (phase_q == GAP_LAST) begin
                    phase_d = '0;
                    state_d = IDLE;
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
            end
        endcase
    end

    // Outputs are derived from the next state so the registered lines line up with it.
    always_comb begin
        sl0_d  = !(((state_d == ACTIVE) && !shift_d[0]) || (state_d == STOP_ACTIVE));
        sl1_d  = !(((state_d == ACTIVE) && shift_d[0]) || (state_d == STOP_ACTIVE));
        busy_d = (state_d != IDLE);
        done_d = (state_d == IFG) && (phase_d == GAP_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            bit_q     <= '0;
            total_q   <= '0;
            shift_q   <= '0;
            sl0_q     <= 1'b1;
            sl1_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            total_q   <= total_d;
            shift_q   <= shift_d;
            sl0_q     <= sl0_d;
            sl1_q     <= sl1_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign sl0     = sl0_q;
    assign sl1     = sl1_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_sl_transmitter.sv
// Directed bench for sl_transmitter: every cycle of each frame is compared against
// the symbol timetable expected for the word, bit count and parity setting.
module tb_sl_transmitter;

    localparam int unsigned H = 8;
    localparam int unsigned G = 16;

    logic        clk;
    logic        rst;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        cfg_enable;
    logic [5:0]  cfg_bit_cnt;
    logic        cfg_parity_en;
    logic        sl0;
    logic        sl1;
    logic        busy;
    logic        done;
    logic        cfg_err;

    int checks = 0;
    int errors = 0;

    sl_transmitter #(
        .HALF_BIT   (H),
        .GAP_CYCLES (G)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .cfg_enable    (cfg_enable),
        .cfg_bit_cnt   (cfg_bit_cnt),
        .cfg_parity_en (cfg_parity_en),
        .sl0           (sl0),
        .sl1           (sl1),
        .busy          (busy),
        .done          (done),
        .cfg_err       (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Packed observation: {sl0, sl1, busy, done, cfg_err, tx_ready}
    function automatic logic [5:0] obs();
        return {sl0, sl1, busy, done, cfg_err, tx_ready};
    endfunction

    // Present a word at a negedge and return right after the posedge that transfers it.
    task automatic send(input logic [31:0] d, input logic [5:0] n, input logic p);
        int t;
        tx_data       = d;
        cfg_bit_cnt   = n;
        cfg_parity_en = p;
        tx_valid      = 1'b1;
        #1;
        t = 0;
        while (!tx_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (!tx_ready) check("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
    endtask

    // Walk cycles N+1..N+lim after a transfer and compare against the expected timetable.
    task automatic check_frame(input logic [31:0] d, input int n, input int p, input int lim,
                               input bit hold, input bit perturb);
        int          len;
        int          slot;
        bit          act;
        logic [31:0] dm;
        logic        par;
        logic        b;
        logic        e0, e1;
        dm = (n >= 32) ? d : (d & ((32'd1 << n) - 32'd1));
        par = ^dm;
        len = (n + p + 1) * 2 * H + G;
        for (int k = 1; k <= lim; k++) begin
            @(negedge clk);
            slot = (k - 1) / (2 * H);
            act  = ((k - 1) % (2 * H)) < H;
            e0 = 1'b1;
            e1 = 1'b1;
            if (act && slot < n + p) begin
                b  = (slot < n) ? dm[slot] : par;
                e0 = b;
                e1 = ~b;
            end else if (act && slot == n + p) begin
                e0 = 1'b0;
                e1 = 1'b0;
            end
            check($sformatf("frame %0h k=%0d", d, k), 64'(obs()),
                  64'({e0, e1, (k <= len), (k == len), 1'b0, (k > len)}));
            if (k == 1 && !hold) tx_valid = 1'b0;
            if (perturb && k == 5) begin
                cfg_bit_cnt = 6'd16;
                tx_data     = 32'h0000_00C3;
            end
            if (perturb && k == 100) cfg_bit_cnt = 6'd8;
        end
    endtask

    initial begin
        rst           = 1'b1;
        tx_data       = '0;
        tx_valid      = 1'b0;
        cfg_enable    = 1'b1;
        cfg_bit_cnt   = 6'd8;
        cfg_parity_en = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_outputs", 64'(obs()), 64'(6'b110001));
        cfg_enable = 1'b0;
        #1;
        check("reset_ready_follows_enable", 64'(tx_ready), 64'd0);
        cfg_enable = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", 64'(obs()), 64'(6'b110001));

        // 0xA5, n=8: done at N+160, ready at N+161
        send(32'h0000_00A5, 6'd8, 1'b0);
        check_frame(32'h0000_00A5, 8, 0, 161, 1'b0, 1'b0);

        // 0x07 with parity: parity symbol is a 1, done at N+176
        send(32'h0000_0007, 6'd8, 1'b1);
        check_frame(32'h0000_0007, 8, 1, 177, 1'b0, 1'b0);

        // All ones, 32 bits: done at N+544
        send(32'hFFFF_FFFF, 6'd32, 1'b0);
        check_frame(32'hFFFF_FFFF, 32, 0, 545, 1'b0, 1'b0);

        // Illegal bit counts are consumed with a single cfg_err pulse
        send(32'h0000_00FF, 6'd7, 1'b0);
        @(negedge clk);
        tx_valid = 1'b0;
        check("bitcnt7_err_pulse", 64'(obs()), 64'(6'b110011));
        @(negedge clk);
        check("bitcnt7_err_clear", 64'(obs()), 64'(6'b110001));
        send(32'h0000_00FF, 6'd33, 1'b0);
        @(negedge clk);
        tx_valid = 1'b0;
        check("bitcnt33_err_pulse", 64'(obs()), 64'(6'b110011));
        @(negedge clk);
        check("bitcnt33_err_clear", 64'(obs()), 64'(6'b110001));

        // Reset at N+50: lines high at N+51, no done afterwards
        send(32'h0000_005A, 6'd8, 1'b0);
        check_frame(32'h0000_005A, 8, 0, 50, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("midframe_reset", 64'(obs()), 64'(6'b110001));
        rst = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            check($sformatf("post_reset_quiet k=%0d", k), 64'(obs()), 64'(6'b110001));
        end
        send(32'h0000_0096, 6'd8, 1'b1);
        check_frame(32'h0000_0096, 8, 1, 177, 1'b0, 1'b0);

        // Back-to-back with tx_valid held: second transfer at N+161
        send(32'h0000_003C, 6'd8, 1'b0);
        check_frame(32'h0000_003C, 8, 0, 161, 1'b1, 1'b1);
        @(posedge clk);
        check_frame(32'h0000_00C3, 8, 0, 161, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
